// File: rtl/instruction_decode.sv
// instruction_decode: RV32I decode stage with a registered output slot and a one-entry pending buffer.
// Define DECODE_RV32M_EN to decode OP funct7=0x01 as mul/div instead of illegal.
module instruction_decode #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_instruction,
    input  logic        i_instruction_valid,
    input  logic [31:0] i_pc,
    input  logic        i_stall,
    input  logic        i_flush,
    output logic        o_fetch_stall,
    output logic        o_valid,
    output logic [31:0] o_pc,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rs2,
    output logic [4:0]  o_rd,
    output logic [31:0] o_imm,
    output logic [3:0]  o_alu_op,
    output logic [2:0]  o_funct3,
    output logic        o_alu_src_imm,
    output logic        o_reg_write,
    output logic        o_is_load,
    output logic        o_is_store,
    output logic        o_is_branch,
    output logic        o_is_jal,
    output logic        o_is_jalr,
    output logic        o_is_auipc,
    output logic        o_is_system,
    output logic        o_is_muldiv,
    output logic        o_illegal
);
`ifdef DECODE_RV32M_EN
    localparam logic M_EN = 1'b1;
`else
    localparam logic M_EN = 1'b0;
`endif
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SRA = 4'd7;
    // funct3-indexed ALU ops: ADD SLL SLT SLTU XOR SRL OR AND
    localparam logic [31:0] BASE_OPS = {4'd9, 4'd8, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd0};

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  alu_op;
        logic [2:0]  funct3;
        logic        alu_src_imm;
        logic        reg_write;
        logic        is_load;
        logic        is_store;
        logic        is_branch;
        logic        is_jal;
        logic        is_jalr;
        logic        is_auipc;
        logic        is_system;
        logic        is_muldiv;
        logic        illegal;
    } dec_t;

    dec_t        d, q;
    logic        prev_valid, pend_valid, slot_valid, accept;
    logic [31:0] pend_instr, pend_pc, slot_pc, w;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [3:0]  base_op;

    assign accept        = i_instruction_valid & ~prev_valid;
    assign o_fetch_stall = i_stall | pend_valid;
    // The pending word has priority: it is always older than anything arriving.
    assign w       = pend_valid ? pend_instr : i_instruction;
    assign opc     = w[6:0];
    assign f3      = w[14:12];
    assign f7      = w[31:25];
    assign base_op = BASE_OPS[{f3, 2'b00} +: 4];
    assign imm_i   = {{20{w[31]}}, w[31:20]};
    assign imm_s   = {{20{w[31]}}, w[31:25], w[11:7]};
    assign imm_b   = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    assign imm_u   = {w[31:12], 12'b0};
    assign imm_j   = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};

    always_comb begin
        d        = '0;
        d.rs1    = w[19:15];
        d.rs2    = w[24:20];
        d.rd     = w[11:7];
        d.funct3 = f3;
        case (opc)
            7'b0110111: begin d.imm = imm_u; d.rs1 = '0; d.alu_src_imm = 1'b1; d.reg_write = 1'b1; end
            7'b0010111: begin d.imm = imm_u; d.alu_src_imm = 1'b1; d.reg_write = 1'b1; d.is_auipc = 1'b1; end
            7'b1101111: begin d.imm = imm_j; d.reg_write = 1'b1; d.is_jal = 1'b1; end
            7'b1100111: begin d.imm = imm_i; d.alu_src_imm = 1'b1; d.reg_write = 1'b1; d.is_jalr = 1'b1; end
            7'b1100011: begin d.imm = imm_b; d.alu_op = ALU_SUB; d.is_branch = 1'b1; end
            7'b0000011: begin d.imm = imm_i; d.alu_src_imm = 1'b1; d.reg_write = 1'b1; d.is_load = 1'b1; end
            7'b0100011: begin d.imm = imm_s; d.alu_src_imm = 1'b1; d.is_store = 1'b1; end
            7'b0010011: begin
                d.imm         = imm_i;
                d.alu_src_imm = 1'b1;
                d.reg_write   = 1'b1;
                d.alu_op      = (f3 == 3'b101 && f7 == 7'h20) ? ALU_SRA : base_op;
                d.illegal     = (f3 == 3'b001 && f7 != 7'h00) || (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20);
            end
            7'b0110011: begin
                d.reg_write = 1'b1;
                d.is_muldiv = M_EN && f7 == 7'h01;
                d.alu_op    = f7 == 7'h20 ? (f3 == 3'b000 ? ALU_SUB : ALU_SRA) : (f7 == 7'h00 ? base_op : ALU_ADD);
                d.illegal   = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)) || d.is_muldiv);
            end
            7'b0001111, 7'b1110011: begin d.imm = imm_i; d.is_system = 1'b1; end
            default: d.illegal = 1'b1;
        endcase
        if (d.illegal)
            {d.imm, d.alu_op, d.alu_src_imm, d.reg_write, d.is_load, d.is_store, d.is_branch,
             d.is_jal, d.is_jalr, d.is_auipc, d.is_system, d.is_muldiv} = 46'd0;
        d.reg_write = d.reg_write && d.rd != 5'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_valid <= 1'b0;
            pend_valid <= 1'b0;
            slot_valid <= 1'b0;
            slot_pc    <= RESET_PC;
            pend_instr <= '0;
            pend_pc    <= '0;
            q          <= '0;
        end else begin
            prev_valid <= i_instruction_valid;
            if (i_flush) begin
                slot_valid <= 1'b0;
                pend_valid <= 1'b0;
            end else if (slot_valid && i_stall) begin
                if (accept && !pend_valid) begin
                    pend_valid <= 1'b1;
                    pend_instr <= i_instruction;
                    pend_pc    <= i_pc;
                end
            end else if (pend_valid) begin
                q          <= d;
                slot_pc    <= pend_pc;
                pend_valid <= accept;
                pend_instr <= i_instruction;
                pend_pc    <= i_pc;
            end else if (accept) begin
                slot_valid <= 1'b1;
                q          <= d;
                slot_pc    <= i_pc;
            end
        end
    end

    assign o_valid       = slot_valid;
    assign o_pc          = slot_valid ? slot_pc : RESET_PC;
    assign o_rs1         = q.rs1;
    assign o_rs2         = q.rs2;
    assign o_rd          = q.rd;
    assign o_imm         = q.imm;
    assign o_alu_op      = q.alu_op;
    assign o_funct3      = q.funct3;
    assign o_alu_src_imm = q.alu_src_imm;
    assign o_reg_write   = q.reg_write;
    assign o_is_load     = q.is_load;
    assign o_is_store    = q.is_store;
    assign o_is_branch   = q.is_branch;
    assign o_is_jal      = q.is_jal;
    assign o_is_jalr     = q.is_jalr;
    assign o_is_auipc    = q.is_auipc;
    assign o_is_system   = q.is_system;
    assign o_is_muldiv   = q.is_muldiv;
    assign o_illegal     = q.illegal;
endmodule

// File: tb/tb_instruction_decode.sv
// tb_instruction_decode: directed and random stimulus against a queue-based scoreboard.
module tb_instruction_decode;
    localparam logic [31:0] RPC = 32'h8000_0000;
`ifdef DECODE_RV32M_EN
    localparam logic M_EN = 1'b1;
`else
    localparam logic M_EN = 1'b0;
`endif
    localparam int F_SRC = 10, F_WR = 9, F_LD = 8, F_ST = 7, F_BR = 6, F_JAL = 5, F_JALR = 4,
                   F_AUIPC = 3, F_SYS = 2, F_MD = 1, F_ILL = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  alu;
        logic [2:0]  f3;
        logic [10:0] fl;
    } exp_t;

    logic        clk = 0, reset = 1;
    logic [31:0] i_instruction = 0, i_pc = 0;
    logic        i_instruction_valid = 0, i_stall = 0, i_flush = 0;
    logic        o_fetch_stall, o_valid;
    logic [31:0] o_pc, o_imm;
    logic [4:0]  o_rs1, o_rs2, o_rd;
    logic [3:0]  o_alu_op;
    logic [2:0]  o_funct3;
    logic        o_alu_src_imm, o_reg_write, o_is_load, o_is_store, o_is_branch, o_is_jal;
    logic        o_is_jalr, o_is_auipc, o_is_system, o_is_muldiv, o_illegal;
    logic [10:0] dut_fl;

    int   checks = 0, errors = 0;
    int   alu_tab [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    exp_t exp_q [$];
    exp_t slot_e, pend_e, cur;
    logic slot_v = 0, pend_v = 0, mprev = 0, pov = 0;

    instruction_decode #(.RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset), .i_instruction(i_instruction),
        .i_instruction_valid(i_instruction_valid), .i_pc(i_pc), .i_stall(i_stall),
        .i_flush(i_flush), .o_fetch_stall(o_fetch_stall), .o_valid(o_valid), .o_pc(o_pc),
        .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd), .o_imm(o_imm), .o_alu_op(o_alu_op),
        .o_funct3(o_funct3), .o_alu_src_imm(o_alu_src_imm), .o_reg_write(o_reg_write),
        .o_is_load(o_is_load), .o_is_store(o_is_store), .o_is_branch(o_is_branch),
        .o_is_jal(o_is_jal), .o_is_jalr(o_is_jalr), .o_is_auipc(o_is_auipc),
        .o_is_system(o_is_system), .o_is_muldiv(o_is_muldiv), .o_illegal(o_illegal)
    );

    assign dut_fl = {o_alu_src_imm, o_reg_write, o_is_load, o_is_store, o_is_branch, o_is_jal,
                     o_is_jalr, o_is_auipc, o_is_system, o_is_muldiv, o_illegal};

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", n, got, want, $time);
        end
    endtask

    // Expected decode built straight from the RV32I field rules.
    function automatic exp_t ref_dec(input logic [31:0] w, input logic [31:0] p);
        exp_t        e;
        int          op, f3, f7;
        logic [31:0] ii;
        logic        ill;
        op = int'(w[6:0]);
        f3 = int'(w[14:12]);
        f7 = int'(w[31:25]);
        ii = $signed(w) >>> 20;
        ill = 0;
        e.pc = p; e.imm = 0; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7];
        e.alu = 0; e.f3 = w[14:12]; e.fl = 0;
        case (op)
            'h37: begin e.imm = w & 32'hFFFF_F000; e.rs1 = 0; e.fl[F_SRC] = 1; e.fl[F_WR] = 1; end
            'h17: begin e.imm = w & 32'hFFFF_F000; e.fl[F_SRC] = 1; e.fl[F_WR] = 1; e.fl[F_AUIPC] = 1; end
            'h6F: begin e.imm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0}; e.fl[F_WR] = 1; e.fl[F_JAL] = 1; end
            'h67: begin e.imm = ii; e.fl[F_SRC] = 1; e.fl[F_WR] = 1; e.fl[F_JALR] = 1; end
            'h63: begin e.imm = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0}; e.alu = 1; e.fl[F_BR] = 1; end
            'h03: begin e.imm = ii; e.fl[F_SRC] = 1; e.fl[F_WR] = 1; e.fl[F_LD] = 1; end
            'h23: begin e.imm = {ii[31:5], w[11:7]}; e.fl[F_SRC] = 1; e.fl[F_ST] = 1; end
            'h13: begin
                e.imm = ii; e.fl[F_SRC] = 1; e.fl[F_WR] = 1;
                e.alu = 4'((f3 == 5 && f7 == 32) ? 7 : alu_tab[f3]);
                ill = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 32);
            end
            'h33: begin
                e.fl[F_WR] = 1;
                if (f7 == 0) e.alu = 4'(alu_tab[f3]);
                else if (f7 == 32 && f3 == 0) e.alu = 1;
                else if (f7 == 32 && f3 == 5) e.alu = 7;
                else if (f7 == 1 && M_EN) e.fl[F_MD] = 1;
                else ill = 1;
            end
            'h0F, 'h73: begin e.imm = ii; e.fl[F_SYS] = 1; end
            default: ill = 1;
        endcase
        if (ill) begin e.imm = 0; e.alu = 0; e.fl = 11'b1; end
        if (e.rd == 0) e.fl[F_WR] = 0;
        return e;
    endfunction

    // Slot/pending occupancy as described by the routing rules; a word entering the slot is pushed to the scoreboard.
    task automatic model(input logic r, v, s, f, input exp_t e);
        logic acc;
        acc = v && !mprev;
        mprev = r ? 1'b0 : v;
        if (r || f) begin
            slot_v = 0; pend_v = 0;
        end else if (pend_v && !s) begin
            slot_e = pend_e; exp_q.push_back(pend_e);
            pend_v = acc; pend_e = e;
        end else if (acc && (!slot_v || !s)) begin
            slot_v = 1; slot_e = e; exp_q.push_back(e);
        end else if (acc && !pend_v) begin
            pend_v = 1; pend_e = e;
        end
    endtask

    task automatic step(input logic r, v, s, f, input logic [31:0] w, p);
        reset = r; i_instruction_valid = v; i_stall = s; i_flush = f; i_instruction = w; i_pc = p;
        @(posedge clk);
        model(r, v, s, f, ref_dec(w, p));
        #1;
    endtask

    function automatic logic [31:0] gen();
        logic [31:0] w;
        logic [6:0]  ops [11];
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
        w = $urandom;
        if ($urandom_range(0, 15) == 0) return w;
        w[6:0] = ops[$urandom_range(0, 10)];
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            2: w[31:25] = 7'h01;
            default: ;
        endcase
        return w;
    endfunction

    always @(negedge clk) begin
        chk("fetch_stall", 32'(o_fetch_stall), 32'(i_stall | pend_v));
        chk("valid", 32'(o_valid), 32'(slot_v));
        if (o_valid && (!pov || o_pc != cur.pc)) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL extra_output got pc %h want no new output", o_pc);
            end else cur = exp_q.pop_front();
        end
        if (o_valid) begin
            chk("pc", o_pc, cur.pc);
            chk("imm", o_imm, cur.imm);
            chk("rs1", 32'(o_rs1), 32'(cur.rs1));
            chk("rs2", 32'(o_rs2), 32'(cur.rs2));
            chk("rd", 32'(o_rd), 32'(cur.rd));
            chk("alu_op", 32'(o_alu_op), 32'(cur.alu));
            chk("funct3", 32'(o_funct3), 32'(cur.f3));
            chk("flags", 32'(dut_fl), 32'(cur.fl));
        end else chk("idle_pc", o_pc, RPC);
        pov = o_valid;
    end

    initial begin
        logic        v, s, f, r;
        logic [31:0] w, pc;
        int          hold;
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_pc", o_pc, RPC);
        chk("rst_imm", o_imm, 0);
        chk("rst_idx", 32'({o_rs1, o_rs2, o_rd}), 0);
        chk("rst_alu_f3", 32'({o_alu_op, o_funct3}), 0);
        chk("rst_flags", 32'(dut_fl), 0);
        chk("rst_fetch_stall", 32'(o_fetch_stall), 0);
        step(0, 1, 0, 0, 32'h0050_0093, 32'h100);
        chk("addi_valid", 32'(o_valid), 1);
        chk("addi_rd", 32'(o_rd), 1);
        chk("addi_rs1", 32'(o_rs1), 0);
        chk("addi_imm", o_imm, 5);
        chk("addi_alu", 32'(o_alu_op), 0);
        chk("addi_src_wr", 32'({o_alu_src_imm, o_reg_write}), 3);
        chk("addi_pc", o_pc, 32'h100);
        step(0, 1, 0, 0, 32'h0050_0093, 32'h100);
        step(0, 1, 0, 0, 32'h0050_0093, 32'h100);
        chk("held_valid", 32'(o_valid), 1);
        chk("held_pc", o_pc, 32'h100);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 32'hFE00_0EE3, 32'h104);
        chk("beq_branch", 32'(o_is_branch), 1);
        chk("beq_imm", o_imm, 32'hFFFF_FFFC);
        chk("beq_wr", 32'(o_reg_write), 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 32'h0220_81B3, 32'h108);
        chk("stall_fetch_stall", 32'(o_fetch_stall), 1);
        chk("stall_hold_pc", o_pc, 32'h104);
        step(0, 0, 0, 0, 0, 0);
        chk("mul_pc", o_pc, 32'h108);
        chk("mul_muldiv", 32'(o_is_muldiv), 32'(M_EN));
        chk("mul_illegal", 32'(o_illegal), 32'(!M_EN));
        step(0, 0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 32'h0010_0113, 32'h10C);
        step(0, 0, 1, 0, 0, 0);
        chk("pend_fetch_stall", 32'(o_fetch_stall), 1);
        step(0, 1, 1, 1, 32'h0020_0193, 32'h110);
        chk("flush_valid", 32'(o_valid), 0);
        step(0, 1, 0, 0, 32'h0020_0193, 32'h110);
        chk("flush_pend_empty", 32'(o_fetch_stall), 0);
        chk("flush_no_reaccept", 32'(o_valid), 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        v = 0; w = 0; pc = 32'h1000; hold = 0;
        for (int k = 0; k < 3000; k++) begin
            s = $urandom_range(0, 3) == 0;
            f = $urandom_range(0, 24) == 0;
            r = k == 1500;
            if (hold > 0) hold--;
            else if (v) v = 0;
            else if (!s && !pend_v && $urandom_range(0, 1) == 1) begin
                v = 1; w = gen(); pc += 4; hold = $urandom_range(0, 2);
            end
            step(r, v, s, f, w, pc);
        end
        repeat (4) step(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
